// File: rtl/reg_file_param_if.sv
// Bus bundle for reg_file_param: write port, read ports,
// clear/dump control and the dump stream.
interface reg_file_param_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) ();
    logic                     we;
    logic [ADDR_W-1:0]        wa;
    logic [DATA_W-1:0]        wd;
    logic [NUM_RD*ADDR_W-1:0] ra;
    logic [NUM_RD*DATA_W-1:0] rd;
    logic                     clr_req;
    logic                     dump_req;
    logic                     busy;
    logic                     dump_valid;
    logic [ADDR_W-1:0]        dump_addr;
    logic [DATA_W-1:0]        dump_data;
    logic                     dump_done;

    modport master (
        output we, wa, wd, ra, clr_req, dump_req,
        input  rd, busy, dump_valid, dump_addr, dump_data, dump_done
    );

    modport slave (
        input  we, wa, wd, ra, clr_req, dump_req,
        output rd, busy, dump_valid, dump_addr, dump_data, dump_done
    );
endinterface

// File: rtl/reg_file_param.sv
// Parametrised multi-read-port register file with optional zero register,
// write bypass, and sequential clear / dump engines.
module reg_file_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    reg_file_param_if.slave   bus
);
    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH-1);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DUMP} state_t;

    state_t              r_state, w_state_nxt;
    logic [ADDR_W:0]     r_cnt, w_cnt_nxt;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                r_busy, w_busy_nxt;
    logic                r_dump_valid, w_dv_nxt;
    logic                r_dump_done, w_done_nxt;
    logic [ADDR_W-1:0]   r_dump_addr, w_daddr_nxt;
    logic [DATA_W-1:0]   r_dump_data, w_ddata_nxt;

    logic                w_idle;
    logic                w_last;
    logic                w_wr_en;
    logic [ADDR_W-1:0]   w_idx;
    logic [NUM_RD*DATA_W-1:0] w_rd;

    assign w_idle  = (r_state == S_IDLE);
    assign w_idx   = r_cnt[ADDR_W-1:0];
    assign w_last  = (r_cnt == LAST);
    assign w_wr_en = w_idle && bus.we &&
                     !(ZERO_REG != 0 && bus.wa == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (bus.clr_req) begin
                    w_state_nxt = S_CLEAR;
                    w_cnt_nxt   = '0;
                end else if (bus.dump_req) begin
                    w_state_nxt = S_DUMP;
                    w_cnt_nxt   = '0;
                end
            end
            S_CLEAR, S_DUMP: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (w_last) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // dump_done fires on the idle cycle right after the last beat was shown
    always_comb begin
        w_busy_nxt  = (w_state_nxt != S_IDLE);
        w_dv_nxt    = (r_state == S_DUMP);
        w_done_nxt  = w_idle && r_dump_valid;
        w_daddr_nxt = r_dump_addr;
        w_ddata_nxt = r_dump_data;
        if (r_state == S_DUMP) begin
            w_daddr_nxt = w_idx;
            w_ddata_nxt = (ZERO_REG != 0 && w_idx == '0) ? '0
                                                         : r_mem[w_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy       <= 1'b0;
            r_dump_valid <= 1'b0;
            r_dump_done  <= 1'b0;
            r_dump_addr  <= '0;
            r_dump_data  <= '0;
        end else begin
            r_busy       <= w_busy_nxt;
            r_dump_valid <= w_dv_nxt;
            r_dump_done  <= w_done_nxt;
            r_dump_addr  <= w_daddr_nxt;
            r_dump_data  <= w_ddata_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (r_state == S_CLEAR) begin
            r_mem[w_idx] <= '0;
        end else if (w_wr_en) begin
            r_mem[bus.wa] <= bus.wd;
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        assign w_ra = bus.ra[g*ADDR_W +: ADDR_W];
        // zero register wins over bypass; w_wr_en already excludes busy
        assign w_rd[g*DATA_W +: DATA_W] =
            (ZERO_REG != 0 && w_ra == '0)            ? '0     :
            (BYPASS != 0 && w_wr_en && bus.wa == w_ra) ? bus.wd :
                                                       r_mem[w_ra];
    end

    assign bus.rd         = w_rd;
    assign bus.busy       = r_busy;
    assign bus.dump_valid = r_dump_valid;
    assign bus.dump_addr  = r_dump_addr;
    assign bus.dump_data  = r_dump_data;
    assign bus.dump_done  = r_dump_done;
endmodule
